// File: rtl/regfile_sb.sv
// Parametrised register file with a post-reset clear sequencer, optional write-to-read
// bypass and a per-register busy scoreboard for outstanding producers.
module regfile_sb #(
    parameter int WIDTH    = 16,
    parameter int AW       = 5,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    r0,
    input  logic [AW-1:0]    r1,
    output logic [WIDTH-1:0] v0,
    output logic [WIDTH-1:0] v1,
    output logic             v0_busy,
    output logic             v1_busy,
    input  logic             we,
    input  logic [AW-1:0]    rd,
    input  logic [WIDTH-1:0] data,
    input  logic             claim,
    input  logic [AW-1:0]    claim_rd,
    output logic             ready
);

    localparam int NREGS = 1 << AW;
    localparam logic [AW-1:0] R_ZERO = AW'(ZERO_REG);
    localparam logic [AW-1:0] CNT_LAST = AW'(NREGS - 1);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t           state;
    logic [AW-1:0]    cnt;
    logic [NREGS-1:0] busy;
    logic [WIDTH-1:0] regs [NREGS];
    logic             wr_en;
    logic             claim_en;
    logic             byp0;
    logic             byp1;

    assign wr_en    = ready && we && (rd != R_ZERO);
    assign claim_en = ready && claim && (claim_rd != R_ZERO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
            busy  <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    // Claim is applied after the clear so a same-register claim wins.
                    if (wr_en)
                        busy[rd] <= 1'b0;
                    if (claim_en)
                        busy[claim_rd] <= 1'b1;
                end
                default: begin
                    state <= INIT;
                    cnt   <= '0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset; the INIT sweep clears it after every reset.
    always_ff @(posedge clk) begin
        if (state == INIT)
            regs[cnt] <= '0;
        else if (wr_en)
            regs[rd] <= data;
    end

    assign byp0 = (BYPASS != 0) && wr_en && (rd == r0);
    assign byp1 = (BYPASS != 0) && wr_en && (rd == r1);

    always_comb begin
        v0      = '0;
        v0_busy = 1'b0;
        if (ready && (r0 != R_ZERO)) begin
            if (byp0) begin
                v0 = data;
            end else begin
                v0      = regs[r0];
                v0_busy = busy[r0];
            end
        end
    end

    always_comb begin
        v1      = '0;
        v1_busy = 1'b0;
        if (ready && (r1 != R_ZERO)) begin
            if (byp1) begin
                v1 = data;
            end else begin
                v1      = regs[r1];
                v1_busy = busy[r1];
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: one instance with bypass, one without, driven in parallel.
module tb_regfile_sb;

    localparam int F_V0 = 0;
    localparam int F_V1 = 1;
    localparam int F_B0 = 2;
    localparam int F_B1 = 3;
    localparam int F_RDY = 4;
    localparam int I_B = 0;
    localparam int I_N = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  r0, r1, rd, claim_rd;
    logic        we, claim;
    logic [15:0] data;

    logic [15:0] v0_b, v1_b, v0_n, v1_n;
    logic        v0_busy_b, v1_busy_b, ready_b;
    logic        v0_busy_n, v1_busy_n, ready_n;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          cyc;
        int          inst;
        int          field;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    regfile_sb #(.WIDTH(16), .AW(5), .ZERO_REG(0), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .r0(r0), .r1(r1), .v0(v0_b), .v1(v1_b),
        .v0_busy(v0_busy_b), .v1_busy(v1_busy_b), .we(we), .rd(rd), .data(data),
        .claim(claim), .claim_rd(claim_rd), .ready(ready_b)
    );

    regfile_sb #(.WIDTH(16), .AW(5), .ZERO_REG(0), .BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .r0(r0), .r1(r1), .v0(v0_n), .v1(v1_n),
        .v0_busy(v0_busy_n), .v1_busy(v1_busy_n), .we(we), .rd(rd), .data(data),
        .claim(claim), .claim_rd(claim_rd), .ready(ready_n)
    );

    function automatic logic [15:0] actual(input int inst, input int field);
        logic [15:0] a;
        a = 16'hxxxx;
        case (field)
            F_V0:  a = (inst == I_B) ? v0_b : v0_n;
            F_V1:  a = (inst == I_B) ? v1_b : v1_n;
            F_B0:  a = {15'd0, (inst == I_B) ? v0_busy_b : v0_busy_n};
            F_B1:  a = {15'd0, (inst == I_B) ? v1_busy_b : v1_busy_n};
            F_RDY: a = {15'd0, (inst == I_B) ? ready_b : ready_n};
            default: a = 16'hxxxx;
        endcase
        return a;
    endfunction

    task automatic push(input int inst, input int field, input logic [15:0] e, input string n);
        exp_t x;
        x.cyc = cyc; x.inst = inst; x.field = field; x.exp = e; x.name = n;
        q.push_back(x);
    endtask

    task automatic push2(input int field, input logic [15:0] e, input string n);
        push(I_B, field, e, n);
        push(I_N, field, e, n);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every expectation due in the current cycle at the falling edge.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [15:0] a;
            e = q.pop_front();
            a = actual(e.inst, e.field);
            n_cmp++;
            if (e.cyc != cyc || a !== e.exp) begin
                n_bad++;
                $display("FAIL %s inst%0d field%0d: got %h want %h (cycle %0d)",
                         e.name, e.inst, e.field, a, e.exp, cyc);
            end
        end
    end

    initial begin
        int regs_used [6];
        regs_used = '{3, 4, 7, 9, 10, 11};
        rst = 1'b1; r0 = '0; r1 = '0; rd = '0; claim_rd = '0;
        we = 1'b0; claim = 1'b0; data = '0;

        repeat (3) step();
        push2(F_RDY, 16'd0, "rst_ready");

        // INIT with writes and claims attempted on reg 5
        rst = 1'b0;
        we = 1'b1; rd = 5'd5; data = 16'hBEEF; claim = 1'b1; claim_rd = 5'd5;
        r0 = 5'd5; r1 = 5'd5;
        for (int k = 1; k <= 32; k++) begin
            step();
            if (k == 32) begin
                we = 1'b0; claim = 1'b0;
            end
            push2(F_RDY, (k == 32) ? 16'd1 : 16'd0, "init_ready");
            push2(F_V0, 16'd0, "init_v0");
            push2(F_B0, 16'd0, "init_busy0");
        end
        #1;
        n_cmp++;
        if (ready_b !== 1'b1) begin
            n_bad++;
            $display("FAIL direct_init_ready_b: got %b", ready_b);
        end
        n_cmp++;
        if (ready_n !== 1'b1) begin
            n_bad++;
            $display("FAIL direct_init_ready_n: got %b", ready_n);
        end

        for (int i = 0; i < 32; i++) begin
            step();
            r0 = 5'(i); r1 = 5'(31 - i);
            push2(F_V0, 16'd0, "clear_v0");
            push2(F_V1, 16'd0, "clear_v1");
            push2(F_B1, 16'd0, "clear_busy1");
        end

        // write / read, zero register
        step(); we = 1'b1; rd = 5'd3; data = 16'h1234; r0 = 5'd0; r1 = 5'd0;
        push2(F_V0, 16'd0, "zero_read");
        step(); we = 1'b1; rd = 5'd0; data = 16'h1234; r0 = 5'd3; r1 = 5'd0;
        push2(F_V0, 16'h1234, "wr_rd3");
        push2(F_V1, 16'd0, "wr_zero_no_bypass");
        #1;
        n_cmp++;
        if (v0_b !== 16'h1234 || v0_n !== 16'h1234) begin
            n_bad++;
            $display("FAIL direct_wr_rd3: got %h / %h", v0_b, v0_n);
        end
        step(); we = 1'b0; r0 = 5'd0; r1 = 5'd3;
        push2(F_V0, 16'd0, "zero_after_write");
        push2(F_V1, 16'h1234, "rd3_port1");

        // bypass
        step(); we = 1'b1; rd = 5'd7; data = 16'hA5A5; r1 = 5'd7;
        push(I_B, F_V1, 16'hA5A5, "bypass_v1");
        push(I_N, F_V1, 16'h0000, "nobypass_v1_old");
        push2(F_B1, 16'd0, "bypass_busy1");
        #1;
        n_cmp++;
        if (v1_b !== 16'hA5A5) begin
            n_bad++;
            $display("FAIL direct_bypass_v1: got %h", v1_b);
        end
        n_cmp++;
        if (v1_n !== 16'h0000) begin
            n_bad++;
            $display("FAIL direct_nobypass_v1: got %h", v1_n);
        end
        step(); we = 1'b0;
        push2(F_V1, 16'hA5A5, "after_bypass_v1");

        // scoreboard
        step(); claim = 1'b1; claim_rd = 5'd9; r0 = 5'd9;
        push2(F_B0, 16'd0, "claim_not_yet");
        step(); claim = 1'b0;
        push2(F_B0, 16'd1, "claimed9");
        #1;
        n_cmp++;
        if (v0_busy_b !== 1'b1 || v0_busy_n !== 1'b1) begin
            n_bad++;
            $display("FAIL direct_claimed9: got %b / %b", v0_busy_b, v0_busy_n);
        end
        step(); we = 1'b1; rd = 5'd9; data = 16'h0999;
        push(I_B, F_B0, 16'd0, "wb_bypass_busy");
        push(I_B, F_V0, 16'h0999, "wb_bypass_v0");
        push(I_N, F_B0, 16'd1, "wb_nobypass_busy");
        push(I_N, F_V0, 16'h0000, "wb_nobypass_v0");
        step(); we = 1'b0;
        push2(F_B0, 16'd0, "after_wb_busy");
        push2(F_V0, 16'h0999, "after_wb_v0");

        // simultaneous claim + write, same register
        step(); claim = 1'b1; claim_rd = 5'd4; we = 1'b1; rd = 5'd4; data = 16'h0042; r0 = 5'd4;
        push(I_B, F_V0, 16'h0042, "same_bypass_v0");
        push(I_N, F_V0, 16'h0000, "same_nobypass_v0");
        push2(F_B0, 16'd0, "same_busy_pre");
        step(); claim = 1'b0; we = 1'b0;
        push2(F_V0, 16'h0042, "same_v0");
        push2(F_B0, 16'd1, "same_busy");

        // simultaneous claim + write, different registers
        step(); claim = 1'b1; claim_rd = 5'd10; we = 1'b1; rd = 5'd11; data = 16'h0BBB;
        r0 = 5'd10; r1 = 5'd11;
        step(); claim = 1'b0; we = 1'b0;
        push2(F_B0, 16'd1, "diff_busy10");
        push2(F_B1, 16'd0, "diff_busy11");
        push2(F_V1, 16'h0BBB, "diff_v11");

        // claim of the zero register
        step(); claim = 1'b1; claim_rd = 5'd0; r0 = 5'd0;
        step(); claim = 1'b0;
        push2(F_B0, 16'd0, "zero_claim_busy");
        push2(F_V0, 16'd0, "zero_claim_v0");

        // re-claim busy register 9
        step(); claim = 1'b1; claim_rd = 5'd9;
        step(); claim = 1'b1; claim_rd = 5'd9;
        step(); claim = 1'b0; r0 = 5'd9;
        push2(F_B0, 16'd1, "reclaim_busy9");

        // asynchronous reset mid-run
        step(); #2; rst = 1'b1;
        push2(F_RDY, 16'd0, "midrst_ready");
        push2(F_B0, 16'd0, "midrst_busy");
        #1;
        n_cmp++;
        if (ready_b !== 1'b0 || v0_busy_b !== 1'b0) begin
            n_bad++;
            $display("FAIL direct_midrst: ready %b busy %b", ready_b, v0_busy_b);
        end
        step();
        push2(F_RDY, 16'd0, "midrst_hold");
        step(); rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            step();
            if (k == 31) push2(F_RDY, 16'd0, "reinit_ready31");
            if (k == 32) begin
                push2(F_RDY, 16'd1, "reinit_ready32");
                push2(F_B0, 16'd0, "reinit_busy9");
                push2(F_V0, 16'd0, "reinit_v9");
            end
        end
        foreach (regs_used[j]) begin
            step(); r0 = 5'(regs_used[j]);
            push2(F_V0, 16'd0, "reinit_clear");
            push2(F_B0, 16'd0, "reinit_busy");
        end

        step(); step();
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s never checked (cycle %0d)", e.name, e.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
